store_merge_unit: RTL and testbench

- Store-side counterpart to the load-path sign/zero extenders. It narrows a 32-bit register value to byte, halfword or word width and places it in the correct little-endian byte lanes.
- The data RAM has no byte enables, so sub-word stores are done as a read-modify-write of the containing word.
- Sits between the EX/MEM stage store request and the single-port synchronous data RAM.

---
 rtl/store_merge_unit.sv | 103 ++++++++++
 tb/tb_store_merge_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/store_merge_unit.sv
// Store-side byte-lane merger: narrows a register value to sw/sh/sb width and
// writes it into a RAM without byte enables using read-modify-write.
module store_merge_unit #(
    parameter int RD_LAT = 1,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_type,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;

    state_t      state, state_nxt;
    logic [1:0]  type_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;
    logic        err_q;
    logic [2:0]  cnt;
    logic        accept;
    logic        req_err;

    // Overlay the narrow store data onto the old word; sw never reaches here.
    function automatic logic [31:0] merge(input logic [1:0] t, input logic [1:0] lane,
                                          input logic [15:0] wd, input logic [31:0] rd);
        logic [31:0] m;
        m = rd;
        if (t == 2'b01) begin
            if (lane[1]) m[31:16] = wd;
            else         m[15:0]  = wd;
        end else begin
            m[{lane, 3'b000} +: 8] = wd[7:0];
        end
        return m;
    endfunction

    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign req_err   = (req_type == 2'b11) ||
                       (req_type == 2'b01 && req_addr[0]) ||
                       (req_type == 2'b00 && req_addr[1:0] != 2'b00);

    assign mem_re = (state == READ);
    assign mem_we = (state == WRITE);
    assign done   = (state == DONE);
    assign err    = (state == DONE) && err_q;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)                  state_nxt = DONE;
                    else if (req_type == 2'b00)   state_nxt = WRITE;
                    else                          state_nxt = READ;
                end
            end
            READ:    state_nxt = WAIT;
            WAIT:    if (cnt == 3'd0) state_nxt = WRITE;
            WRITE:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mem_addr  <= '0;
            mem_wdata <= '0;
            err_q     <= 1'b0;
            cnt       <= 3'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                type_q  <= req_type;
                lane_q  <= req_addr[1:0];
                wdata_q <= req_wdata[15:0];
                err_q   <= req_err;
                if (!req_err) mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
                if (!req_err && req_type == 2'b00) mem_wdata <= req_wdata;
            end
            if (state == READ) cnt <= 3'(RD_LAT - 1);
            // Final WAIT cycle: read data is valid, fold it into the write word.
            if (state == WAIT) begin
                cnt <= cnt - 3'd1;
                if (cnt == 3'd0) mem_wdata <= merge(type_q, lane_q, wdata_q, mem_rdata);
            end
        end
    end

endmodule

// File: tb/tb_store_merge_unit.sv
// Directed bench for store_merge_unit: two instances (RD_LAT=1 and RD_LAT=3)
// each backed by a behavioural latency-matched RAM.
module tb_store_merge_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rv1, rv3;
    logic [1:0]  rtype;
    logic [31:0] raddr, rwdata;

    logic        rdy1, mre1, mwe1, done1, err1;
    logic [31:0] maddr1, mrdata1, mwdata1;
    logic        rdy3, mre3, mwe3, done3, err3;
    logic [31:0] maddr3, mrdata3, mwdata3;

    int tests = 0;
    int fails = 0;

    store_merge_unit #(.RD_LAT(1), .ADDR_W(32)) dut1 (
        .clk(clk), .rst(rst), .req_valid(rv1), .req_ready(rdy1), .req_type(rtype),
        .req_addr(raddr), .req_wdata(rwdata), .mem_addr(maddr1), .mem_re(mre1),
        .mem_rdata(mrdata1), .mem_we(mwe1), .mem_wdata(mwdata1), .done(done1), .err(err1));

    store_merge_unit #(.RD_LAT(3), .ADDR_W(32)) dut3 (
        .clk(clk), .rst(rst), .req_valid(rv3), .req_ready(rdy3), .req_type(rtype),
        .req_addr(raddr), .req_wdata(rwdata), .mem_addr(maddr3), .mem_re(mre3),
        .mem_rdata(mrdata3), .mem_we(mwe3), .mem_wdata(mwdata3), .done(done3), .err(err3));

    // RAM models: read data shows up RD_LAT cycles after the mem_re cycle;
    // outside that slot the bus carries a junk pattern.
    logic [31:0] ram1 [64];
    logic [31:0] ram3 [64];
    logic [31:0] pipe1 [4];
    logic [31:0] pipe3 [4];
    logic        pk = 1'b0;
    logic [5:0]  pk_idx = '0;
    logic [31:0] pk_val = '0;

    always @(posedge clk) begin
        if (pk) begin
            ram1[pk_idx] <= pk_val;
            ram3[pk_idx] <= pk_val;
        end else begin
            if (mwe1) ram1[maddr1[7:2]] <= mwdata1;
            if (mwe3) ram3[maddr3[7:2]] <= mwdata3;
        end
        pipe1[0] <= mre1 ? ram1[maddr1[7:2]] : 32'h0BAD0BAD;
        pipe3[0] <= mre3 ? ram3[maddr3[7:2]] : 32'h0BAD0BAD;
        for (int i = 1; i < 4; i++) begin
            pipe1[i] <= pipe1[i-1];
            pipe3[i] <= pipe3[i-1];
        end
    end
    assign mrdata1 = pipe1[0];
    assign mrdata3 = pipe3[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic poke(input int idx, input logic [31:0] val);
        pk = 1'b1; pk_idx = 6'(idx); pk_val = val;
        @(posedge clk); #1;
        pk = 1'b0;
    endtask

    task automatic check_inst(input string tag, input int lat, input logic [1:0] t,
                              input logic exp_err, input logic [31:0] exp_addr,
                              input logic [31:0] exp_wd, input int nre, input int re_c,
                              input int nwe, input int we_c, input int nd, input int d_c,
                              input logic e, input logic [31:0] wa, input logic [31:0] wd,
                              input logic rdy_at_d, input logic rdy_after_d);
        int exp_d;
        exp_d = exp_err ? 1 : ((t == 2'b00) ? 2 : 3 + lat);
        chk({tag, " done_count"}, nd, 1);
        chk({tag, " done_cycle"}, d_c, exp_d);
        chk({tag, " err"}, {31'b0, e}, {31'b0, exp_err});
        chk({tag, " ready_at_done"}, {31'b0, rdy_at_d}, 0);
        chk({tag, " ready_after_done"}, {31'b0, rdy_after_d}, 1);
        if (exp_err) begin
            chk({tag, " re_count"}, nre, 0);
            chk({tag, " we_count"}, nwe, 0);
        end else begin
            chk({tag, " re_count"}, nre, (t == 2'b00) ? 0 : 1);
            if (t != 2'b00) chk({tag, " re_cycle"}, re_c, 1);
            chk({tag, " we_count"}, nwe, 1);
            chk({tag, " we_cycle"}, we_c, (t == 2'b00) ? 1 : 2 + lat);
            chk({tag, " mem_addr"}, wa, exp_addr);
            chk({tag, " mem_wdata"}, wd, exp_wd);
        end
    endtask

    task automatic run_req(input string tag, input logic [1:0] t, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] exp_wd,
                           input logic exp_err);
        int nre1, rec1, nwe1, wec1, nd1, dc1, nre3, rec3, nwe3, wec3, nd3, dc3;
        logic e1, e3, both;
        logic [31:0] wa1, wd1, wa3, wd3;
        logic r1 [16];
        logic r3 [16];
        nre1 = 0; rec1 = -1; nwe1 = 0; wec1 = -1; nd1 = 0; dc1 = 0;
        nre3 = 0; rec3 = -1; nwe3 = 0; wec3 = -1; nd3 = 0; dc3 = 0;
        e1 = 0; e3 = 0; both = 0; wa1 = 0; wd1 = 0; wa3 = 0; wd3 = 0;
        for (int i = 0; i < 16; i++) begin r1[i] = 0; r3[i] = 0; end
        rtype = t; raddr = a; rwdata = wd; rv1 = 1'b1; rv3 = 1'b1;
        chk({tag, " ready/L1"}, {31'b0, rdy1}, 1);
        chk({tag, " ready/L3"}, {31'b0, rdy3}, 1);
        @(posedge clk); #1;
        rv1 = 1'b0; rv3 = 1'b0; rtype = 2'b11; raddr = 32'hFFFF_FFFF; rwdata = 32'h0;
        for (int k = 1; k < 12; k++) begin
            if (mre1) begin nre1++; if (rec1 < 0) rec1 = k; end
            if (mwe1) begin nwe1++; wec1 = k; wa1 = maddr1; wd1 = mwdata1; end
            if (done1) begin nd1++; dc1 = k; e1 = err1; end
            if (mre3) begin nre3++; if (rec3 < 0) rec3 = k; end
            if (mwe3) begin nwe3++; wec3 = k; wa3 = maddr3; wd3 = mwdata3; end
            if (done3) begin nd3++; dc3 = k; e3 = err3; end
            if ((mre1 && mwe1) || (mre3 && mwe3)) both = 1'b1;
            r1[k] = rdy1; r3[k] = rdy3;
            @(posedge clk); #1;
        end
        chk({tag, " re_and_we_overlap"}, {31'b0, both}, 0);
        check_inst({tag, "/L1"}, 1, t, exp_err, {a[31:2], 2'b00}, exp_wd, nre1, rec1,
                   nwe1, wec1, nd1, dc1, e1, wa1, wd1, r1[dc1], r1[dc1 + 1]);
        check_inst({tag, "/L3"}, 3, t, exp_err, {a[31:2], 2'b00}, exp_wd, nre3, rec3,
                   nwe3, wec3, nd3, dc3, e3, wa3, wd3, r3[dc3], r3[dc3 + 1]);
    endtask

    initial begin
        int acc [4];
        int dn [4];
        int na, nd, nbad;
        logic fired;
        rst = 1'b1; rv1 = 1'b0; rv3 = 1'b0; rtype = 2'b00; raddr = 32'h0; rwdata = 32'h0;
        @(posedge clk); #1;
        poke(8, 32'h1122_3344);
        poke(9, 32'hAAAA_BBBB);
        poke(16, 32'h0000_0000);
        poke(20, 32'h0000_0000);
        poke(21, 32'h1234_5678);
        poke(22, 32'h9999_AAAA);

        // Reset state
        chk("reset ready/L1", {31'b0, rdy1}, 0);
        chk("reset ready/L3", {31'b0, rdy3}, 0);
        chk("reset strobes", {26'b0, mre1, mwe1, done1, mre3, mwe3, done3}, 0);
        chk("reset err", {30'b0, err1, err3}, 0);
        chk("reset mem_addr", maddr1 | maddr3, 0);
        chk("reset mem_wdata", mwdata1 | mwdata3, 0);
        rst = 1'b0; #1;
        chk("post-reset ready", {30'b0, rdy1, rdy3}, 2'b11);

        run_req("sw 0x10", 2'b00, 32'h10, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
        run_req("sb 0x22", 2'b10, 32'h22, 32'hFFFF_FFAB, 32'h11AB_3344, 1'b0);
        run_req("sh 0x26", 2'b01, 32'h26, 32'h0000_CAFE, 32'hCAFE_BBBB, 1'b0);
        poke(9, 32'hAAAA_BBBB);
        run_req("sh 0x24", 2'b01, 32'h24, 32'h0000_CAFE, 32'hAAAA_CAFE, 1'b0);
        run_req("sh mis 0x31", 2'b01, 32'h31, 32'h1234_5678, 32'h0, 1'b1);
        run_req("sw mis 0x32", 2'b00, 32'h32, 32'h1234_5678, 32'h0, 1'b1);
        run_req("illegal type", 2'b11, 32'h40, 32'h1234_5678, 32'h0, 1'b1);
        run_req("sb 0x43", 2'b10, 32'h43, 32'h0000_005A, 32'h5A00_0000, 1'b0);
        chk("ram 0x40/L1", ram1[16], 32'h5A00_0000);
        chk("ram 0x40/L3", ram3[16], 32'h5A00_0000);

        // Reset while waiting on read data: no write may escape.
        rtype = 2'b10; raddr = 32'h41; rwdata = 32'h77; rv1 = 1'b1; rv3 = 1'b1;
        @(posedge clk); #1;
        rv1 = 1'b0; rv3 = 1'b0;
        chk("abort read strobe", {30'b0, mre1, mre3}, 2'b11);
        @(posedge clk); #1;
        rst = 1'b1; #1;
        chk("abort ready in rst", {30'b0, rdy1, rdy3}, 0);
        @(posedge clk); #1;
        rst = 1'b0; #1;
        chk("abort ready after rst", {30'b0, rdy1, rdy3}, 2'b11);
        chk("abort mem_addr cleared", maddr1 | maddr3, 0);
        nbad = 0;
        for (int k = 0; k < 6; k++) begin
            if (mwe1 || mwe3 || done1 || done3 || mre1 || mre3) nbad++;
            @(posedge clk); #1;
        end
        chk("abort stray strobes", nbad, 0);
        chk("abort ram/L1", ram1[16], 32'h5A00_0000);
        chk("abort ram/L3", ram3[16], 32'h5A00_0000);

        // Back-to-back on the RD_LAT=1 instance with req_valid held high.
        na = 0; nd = 0;
        for (int i = 0; i < 4; i++) begin acc[i] = -1; dn[i] = -1; end
        rtype = 2'b00; raddr = 32'h50; rwdata = 32'h0102_0304; rv1 = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (done1) begin if (nd < 4) dn[nd] = c; nd++; end
            fired = rv1 && rdy1;
            if (fired) begin if (na < 4) acc[na] = c; na++; end
            @(posedge clk); #1;
            if (fired) begin
                case (na)
                    1: begin rtype = 2'b10; raddr = 32'h55; rwdata = 32'h0000_00EE; end
                    2: begin rtype = 2'b01; raddr = 32'h58; rwdata = 32'h0000_BEEF; end
                    default: rv1 = 1'b0;
                endcase
            end
        end
        rv1 = 1'b0;
        chk("b2b accepts", na, 3);
        chk("b2b done pulses", nd, 3);
        chk("b2b sw latency", dn[0] - acc[0], 2);
        chk("b2b accept1 after done0", acc[1], dn[0] + 1);
        chk("b2b sb latency", dn[1] - acc[1], 4);
        chk("b2b accept2 after done1", acc[2], dn[1] + 1);
        chk("b2b sh latency", dn[2] - acc[2], 4);
        chk("b2b ram 0x50", ram1[20], 32'h0102_0304);
        chk("b2b ram 0x54", ram1[21], 32'h1234_EE78);
        chk("b2b ram 0x58", ram1[22], 32'h9999_BEEF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
